// File: rtl/multicycle_controller_if.sv
// Memory request handshake shared between the multicycle controller and the
// combined instruction/data memory port.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic MemSrcPC;
  logic MemReady;

  modport master (
    output MemReq,
    output MemWrite,
    output MemSrcPC,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  MemSrcPC,
    output MemReady
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle RV32I datapath (fetch, decode, execute,
// memory, writeback); also counts retired instructions and traps bad opcodes.
module multicycle_controller #(
  parameter int RETIRE_W = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  multicycle_controller_if.master mem,
  input  logic [6:0]            Opcode,
  input  logic                  BranchTaken,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [2:0]            ImGenControl,
  output logic                  Illegal,
  output logic [RETIRE_W-1:0]   RetireCount
);

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_EXEC_I  = 4'd4;
  localparam logic [3:0] S_ADDR    = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_WB_ALU  = 4'd8;
  localparam logic [3:0] S_WB_LOAD = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JAL     = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_NONE = 3'b100;

  logic [3:0]          state_q, state_d;
  logic [2:0]          imgen_q, imgen_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic       mem_req, mem_write, mem_src_pc;
  logic       ir_we, pc_we, reg_we, retire;
  logic       pc_src, alu_src_b;
  logic [1:0] result_src, alu_op;

  always_comb begin
    state_d    = state_q;
    imgen_d    = imgen_q;
    illegal_d  = illegal_q;
    retire_d   = retire_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_src_pc = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    result_src = 2'b00;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    retire     = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_src_pc = 1'b1;
        if (mem.MemReady) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_R:      begin state_d = S_EXEC_R; imgen_d = IMM_NONE; end
          OP_I:      begin state_d = S_EXEC_I; imgen_d = IMM_I;    end
          OP_LOAD:   begin state_d = S_ADDR;   imgen_d = IMM_I;    end
          OP_STORE:  begin state_d = S_ADDR;   imgen_d = IMM_S;    end
          OP_BRANCH: begin state_d = S_BRANCH; imgen_d = IMM_B;    end
          OP_JAL:    begin state_d = S_JAL;    imgen_d = IMM_J;    end
          default:   begin state_d = S_TRAP;   imgen_d = IMM_NONE; end
        endcase
      end
      S_EXEC_R: begin
        alu_op  = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_ADDR: begin
        alu_src_b = 1'b1;
        state_d   = Opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem.MemReady) state_d = S_WB_LOAD;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_LOAD: begin
        reg_we     = 1'b1;
        result_src = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op  = 2'b01;
        pc_we   = BranchTaken;
        pc_src  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        reg_we     = 1'b1;
        result_src = 2'b10;
        pc_we      = 1'b1;
        pc_src     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RST;
    endcase

    if (retire) retire_d = retire_q + RETIRE_W'(1);
    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_RST;
      imgen_q   <= IMM_NONE;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      imgen_q   <= imgen_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
    end
  end

  assign mem.MemReq   = mem_req;
  assign mem.MemWrite = mem_write;
  assign mem.MemSrcPC = mem_src_pc;

  // Architectural write strobes are suppressed while Reset is low so a
  // discarded instruction never commits anything in the reset cycle.
  assign IRWrite      = ir_we & Reset;
  assign PCWrite      = pc_we & Reset;
  assign RegWrite     = reg_we & Reset;
  assign PCSrc        = pc_src;
  assign ResultSrc    = result_src;
  assign ALUSrcB      = alu_src_b;
  assign ALUOp        = alu_op;
  assign ImGenControl = imgen_q;
  assign Illegal      = illegal_q;
  assign RetireCount  = retire_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: randomized instruction mix and
// memory wait states checked against a per-instruction behavioural model.
module tb_multicycle_controller;
  localparam int RW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          ir_write, pc_write, pc_src, reg_write, alu_src_b, illegal;
  logic [1:0]    result_src, alu_op;
  logic [2:0]    imgen;
  logic [RW-1:0] retire_count;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            exp_retire = 0;
  logic [2:0]    exp_imgen = 3'b100;

  multicycle_controller_if bus ();

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .mem          (bus),
    .Opcode       (opcode),
    .BranchTaken  (branch_taken),
    .IRWrite      (ir_write),
    .PCWrite      (pc_write),
    .PCSrc        (pc_src),
    .RegWrite     (reg_write),
    .ResultSrc    (result_src),
    .ALUSrcB      (alu_src_b),
    .ALUOp        (alu_op),
    .ImGenControl (imgen),
    .Illegal      (illegal),
    .RetireCount  (retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0:       return OP_R;
      1:       return OP_I;
      2:       return OP_LOAD;
      3:       return OP_STORE;
      4:       return OP_BRANCH;
      default: return OP_JAL;
    endcase
  endfunction

  // Runs one legal instruction from FETCH to retirement (called at posedge+1 in
  // FETCH) and compares its observed strobe profile against the model.
  task automatic run_instr(input string name, input logic [6:0] op, input int fw,
                           input int mw, input logic taken);
    int cycles, transfers, fw_left, mw_left, irw, regw, pcw, memw, aluop01;
    int exp_cycles, exp_regw, exp_pcw, exp_memw, exp_xfer, exp_aluop01;
    logic [1:0] rs, exp_rs;
    logic pcsrc_last, src2, srcb, exp_pcsrc, exp_srcb;
    logic [2:0] imgen_new;
    logic [RW-1:0] r0;
    bit stable_ok, prev_wait, prev_we, prev_src, done;

    exp_regw = 0; exp_pcw = 1; exp_pcsrc = 1'b0; exp_memw = 0; exp_xfer = 1;
    exp_rs = 2'b00; exp_srcb = 1'b0; exp_aluop01 = 0; exp_cycles = 0; imgen_new = 3'b100;
    case (op)
      OP_R:      begin exp_cycles = 4; exp_regw = 1; exp_srcb = 1'b0; imgen_new = 3'b100; end
      OP_I:      begin exp_cycles = 4; exp_regw = 1; exp_srcb = 1'b1; imgen_new = 3'b000; end
      OP_LOAD:   begin exp_cycles = 5 + mw; exp_regw = 1; exp_rs = 2'b01; exp_xfer = 2; imgen_new = 3'b000; end
      OP_STORE:  begin exp_cycles = 4 + mw; exp_memw = mw + 1; exp_xfer = 2; imgen_new = 3'b001; end
      OP_BRANCH: begin exp_cycles = 3; exp_pcw = taken ? 2 : 1; exp_pcsrc = taken; exp_aluop01 = 1; imgen_new = 3'b010; end
      default:   begin exp_cycles = 3; exp_regw = 1; exp_rs = 2'b10; exp_pcw = 2; exp_pcsrc = 1'b1; imgen_new = 3'b011; end
    endcase
    exp_cycles += fw;

    cycles = 0; transfers = 0; fw_left = fw; mw_left = mw;
    irw = 0; regw = 0; pcw = 0; memw = 0; aluop01 = 0;
    rs = 2'b11; pcsrc_last = 1'b0; src2 = 1'b1; srcb = 1'bx;
    stable_ok = 1'b1; prev_wait = 1'b0; prev_we = 1'b0; prev_src = 1'b0; done = 1'b0;
    r0 = retire_count;
    opcode = op;
    branch_taken = taken;

    while (!done) begin
      if (bus.MemReq) bus.MemReady = (transfers == 0) ? (fw_left == 0) : (mw_left == 0);
      else            bus.MemReady = 1'($urandom_range(0, 1));
      if (prev_wait && (bus.MemReq !== 1'b1 || bus.MemWrite !== prev_we || bus.MemSrcPC !== prev_src))
        stable_ok = 1'b0;
      #1;
      cycles++;
      if (ir_write) irw++;
      if (reg_write) begin regw++; rs = result_src; end
      if (pc_write) begin pcw++; pcsrc_last = pc_src; end
      if (bus.MemReq && bus.MemWrite) memw++;
      if (alu_op == 2'b10) srcb = alu_src_b;
      if (alu_op == 2'b01) aluop01++;
      if (bus.MemReq) begin
        if (bus.MemReady) begin
          if (transfers == 1) src2 = bus.MemSrcPC;
          transfers++;
        end else if (transfers == 0) fw_left--;
        else mw_left--;
      end
      prev_wait = bus.MemReq && !bus.MemReady;
      prev_we   = bus.MemWrite;
      prev_src  = bus.MemSrcPC;
      @(posedge clk); #1;
      if (retire_count !== r0) done = 1'b1;
      else if (cycles >= 60) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL %s timeout: no retire after %0d cycles, expected %0d", name, cycles, exp_cycles);
        return;
      end
    end

    exp_retire = (exp_retire + 1) % (1 << RW);
    exp_imgen  = imgen_new;

    tests_run++; if (cycles !== exp_cycles) begin tests_failed++; $display("[TB] FAIL %s cycles: got %0d expected %0d", name, cycles, exp_cycles); end
    tests_run++; if (retire_count !== RW'(exp_retire)) begin tests_failed++; $display("[TB] FAIL %s retire: got %0d expected %0d", name, retire_count, exp_retire); end
    tests_run++; if (irw !== 1) begin tests_failed++; $display("[TB] FAIL %s irwrite pulses: got %0d expected 1", name, irw); end
    tests_run++; if (regw !== exp_regw) begin tests_failed++; $display("[TB] FAIL %s regwrite cycles: got %0d expected %0d", name, regw, exp_regw); end
    if (exp_regw == 1) begin
      tests_run++; if (rs !== exp_rs) begin tests_failed++; $display("[TB] FAIL %s resultsrc: got %b expected %b", name, rs, exp_rs); end
    end
    tests_run++; if (pcw !== exp_pcw || pcsrc_last !== exp_pcsrc) begin tests_failed++; $display("[TB] FAIL %s pcwrite: got %0d/src %b expected %0d/src %b", name, pcw, pcsrc_last, exp_pcw, exp_pcsrc); end
    tests_run++; if (memw !== exp_memw) begin tests_failed++; $display("[TB] FAIL %s memwrite cycles: got %0d expected %0d", name, memw, exp_memw); end
    tests_run++; if (transfers !== exp_xfer) begin tests_failed++; $display("[TB] FAIL %s transfers: got %0d expected %0d", name, transfers, exp_xfer); end
    if (exp_xfer == 2) begin
      tests_run++; if (src2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s data addr src: got %b expected 0", name, src2); end
    end
    if (op == OP_R || op == OP_I) begin
      tests_run++; if (srcb !== exp_srcb) begin tests_failed++; $display("[TB] FAIL %s alusrcb: got %b expected %b", name, srcb, exp_srcb); end
    end
    tests_run++; if (aluop01 !== exp_aluop01) begin tests_failed++; $display("[TB] FAIL %s compare op cycles: got %0d expected %0d", name, aluop01, exp_aluop01); end
    tests_run++; if (imgen !== exp_imgen) begin tests_failed++; $display("[TB] FAIL %s imgen: got %b expected %b", name, imgen, exp_imgen); end
    tests_run++; if (!stable_ok) begin tests_failed++; $display("[TB] FAIL %s handshake stability: got unstable expected stable", name); end
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s illegal: got %b expected 0", name, illegal); end
  endtask

  task automatic test_reset();
    logic [4:0] exp_tab [5] = '{5'b00000, 5'b11000, 5'b00000, 5'b00010, 5'b00100};
    logic [4:0] obs;
    rst_n = 1'b0; bus.MemReady = 1'b1; opcode = OP_R; branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.MemReq, ir_write, reg_write, alu_op};
    tests_run++; if (obs !== 5'b00000 || imgen !== 3'b100 || illegal !== 1'b0 || retire_count !== '0) begin
      tests_failed++; $display("[TB] FAIL reset state: got strobes %b imgen %b illegal %b retire %0d expected 00000/100/0/0", obs, imgen, illegal, retire_count);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      obs = {bus.MemReq, ir_write, reg_write, alu_op};
      tests_run++; if (obs !== exp_tab[c]) begin tests_failed++; $display("[TB] FAIL reset release cycle %0d: got %b expected %b", c + 1, obs, exp_tab[c]); end
      @(posedge clk); #1;
    end
    exp_retire = 1; exp_imgen = 3'b100;
    tests_run++; if (retire_count !== RW'(1) || imgen !== 3'b100) begin
      tests_failed++; $display("[TB] FAIL first retire: got %0d/%b expected 1/100", retire_count, imgen);
    end
  endtask

  task automatic test_load();
    run_instr("load waits", OP_LOAD, 2, 2, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("branch taken", OP_BRANCH, 0, 0, 1'b1);
    run_instr("branch not taken", OP_BRANCH, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b store", OP_STORE, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    run_instr("b2b jal", OP_JAL, $urandom_range(0, 2), 0, 1'b0);
  endtask

  task automatic test_random_wrap();
    for (int n = 0; n < 24; n++)
      run_instr("random", pick_op($urandom_range(0, 5)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    while (exp_retire != (1 << RW) - 1)
      run_instr("pre-wrap", pick_op($urandom_range(0, 5)), 0, 0, 1'b1);
    run_instr("wrap", OP_I, 0, 0, 1'b0);
    tests_run++; if (retire_count !== '0) begin tests_failed++; $display("[TB] FAIL counter wrap: got %0d expected 0", retire_count); end
  endtask

  task automatic test_reset_midop();
    opcode = OP_STORE; bus.MemReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.MemReady = 1'b0; #1;
    tests_run++; if ({bus.MemReq, bus.MemWrite} !== 2'b11) begin tests_failed++; $display("[TB] FAIL store request: got %b expected 11", {bus.MemReq, bus.MemWrite}); end
    @(posedge clk); #1;
    rst_n = 1'b0; bus.MemReady = 1'b1; #1;
    tests_run++; if ({reg_write, ir_write, pc_write} !== 3'b000) begin tests_failed++; $display("[TB] FAIL strobes in reset cycle: got %b expected 000", {reg_write, ir_write, pc_write}); end
    @(posedge clk); #1;
    tests_run++; if (bus.MemReq !== 1'b0 || retire_count !== '0 || imgen !== 3'b100) begin
      tests_failed++; $display("[TB] FAIL after midop reset: got req %b retire %0d imgen %b expected 0/0/100", bus.MemReq, retire_count, imgen);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    tests_run++; if ({ir_write, pc_write} !== 2'b00) begin tests_failed++; $display("[TB] FAIL fetch strobes under reset: got %b expected 00", {ir_write, pc_write}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_retire = 0; exp_imgen = 3'b100;
    run_instr("after reset", OP_R, 1, 0, 1'b0);
  endtask

  task automatic test_trap();
    bit bad = 1'b0;
    opcode = OP_SYS; bus.MemReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++; if (illegal !== 1'b1 || imgen !== 3'b100) begin tests_failed++; $display("[TB] FAIL trap entry: got illegal %b imgen %b expected 1/100", illegal, imgen); end
    for (int c = 0; c < 10; c++) begin
      bus.MemReady = 1'($urandom_range(0, 1)); #1;
      if (bus.MemReq || ir_write || pc_write || reg_write || illegal !== 1'b1 || retire_count !== RW'(exp_retire)) bad = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++; if (bad) begin tests_failed++; $display("[TB] FAIL trap hold: got activity or count change expected idle with retire %0d", exp_retire); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ({illegal, retire_count, imgen} !== {1'b0, RW'(0), 3'b100}) begin
      tests_failed++; $display("[TB] FAIL trap reset: got illegal %b retire %0d imgen %b expected 0/0/100", illegal, retire_count, imgen);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_branch();
    test_back_to_back();
    test_random_wrap();
    test_reset_midop();
    test_trap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback.
- Drives the immediate generator's format select (ImGenControl), register/PC/IR write strobes, ALU operand/op selects and the memory request handshake.
- Also tracks retired instructions and flags unsupported opcodes.
- Sits between the shared instruction/data memory port and the register file/ALU/immediate-generator datapath.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Opcode  in  7  Instruction[6:0] from the instruction register
- BranchTaken  in  1  ALU compare result for the current branch, valid in BRANCH state
- MemReady  in  1  memory completes the current request this cycle
- MemReq  out  1  memory request valid, held until MemReady
- MemWrite  out  1  request is a store (qualifies MemReq)
- MemSrcPC  out  1  1 = address from PC (fetch), 0 = from ALU result
- IRWrite  out  1  load instruction register
- PCWrite  out  1  update PC
- PCSrc  out  1  0 = PC+4, 1 = PC+Immediate
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALU, 01 memory data, 10 PC+4
- ALUSrcB  out  1  0 = rs2, 1 = Immediate
- ALUOp  out  2  00 add, 01 compare (branch), 10 funct-decoded
- ImGenControl  out  3  000 I/load, 001 S, 010 B, 011 J, 100 none
- Illegal  out  1  sticky unsupported-opcode flag
- RetireCount  out  RETIRE_W  count of completed instructions

Behaviour:
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_LOAD, BRANCH, JAL, TRAP.
- Reset:
  - Reset low at a rising edge → state RST, ImGenControl=100, Illegal=0, RetireCount=0.
  - All strobes are 0 in RST.
  - RST → FETCH unconditionally on the next edge.
  - Reset mid-operation discards the instruction; no strobe fires in the reset cycle.
- FETCH: MemReq=1, MemSrcPC=1, MemWrite=0.
  - MemReady=0 → stay.
  - MemReady=1 → IRWrite=1 and PCWrite=1 (PCSrc=0) that same cycle, then → DECODE.
- DECODE: registers ImGenControl from Opcode, held until the next DECODE.
  - 0110011 R → EXEC_R, ImGen 100.
  - 0010011 I-ALU → EXEC_I, ImGen 000.
  - 0000011 load → ADDR, ImGen 000.
  - 0100011 store → ADDR, ImGen 001.
  - 1100011 branch → BRANCH, ImGen 010.
  - 1101111 JAL → JAL, ImGen 011.
  - Any other opcode → TRAP, ImGen 100.
- EXEC_R: ALUSrcB=0, ALUOp=10 → WB_ALU.
- EXEC_I: ALUSrcB=1, ALUOp=10 → WB_ALU.
- WB_ALU: RegWrite=1, ResultSrc=00, retire → FETCH.
- ADDR: ALUSrcB=1, ALUOp=00. Load → MEM_RD, store → MEM_WR (opcode bit 5 selects).
- MEM_RD: MemReq=1, MemSrcPC=0. Wait on MemReady, then → WB_LOAD.
- WB_LOAD: RegWrite=1, ResultSrc=01, retire → FETCH.
- MEM_WR: MemReq=1, MemWrite=1, MemSrcPC=0. On MemReady, retire → FETCH.
- BRANCH: ALUOp=01. PCWrite=BranchTaken, PCSrc=1, retire → FETCH.
  - Since PC already holds PC+4, the datapath supplies the old PC for the target; that is not this block's concern.
- JAL: RegWrite=1, ResultSrc=10, PCWrite=1, PCSrc=1, retire → FETCH.
- TRAP: Illegal=1. All strobes 0, no retire. Stays until Reset.
- Retire: RetireCount += 1 on the final cycle of each instruction. Wraps from all-ones to 0.
- Handshake:
  - MemReq rises only on entry to FETCH/MEM_RD/MEM_WR.
  - Address and MemWrite are stable while MemReq=1 and MemReady=0.
  - Exactly one transfer per MemReq assertion.
  - MemReady while MemReq=0 is ignored.
- Latency with MemReady tied 1 (cycles per instruction):
  - R/I-ALU 4; load 5; store 4; branch 3; JAL 3.
  - Each memory wait cycle adds 1.
- Outputs other than ImGenControl, Illegal and RetireCount decode combinationally from state only. MemReady affects only transitions and the FETCH IRWrite/PCWrite strobes.

Test Plan:
- Reset held low 3 cycles, then released with MemReady=1, Opcode=0110011 → FETCH on cycle 2, WB_ALU RegWrite on cycle 5, RetireCount=1, ImGenControl=100.
- Load (0000011) with MemReady low for 2 cycles in both FETCH and MEM_RD → 9 cycles, MemReq held steady, a single IRWrite pulse, WB_LOAD with ResultSrc=01, ImGenControl=000.
- Branch (1100011): BranchTaken=1 → PCWrite=1, PCSrc=1 in BRANCH. BranchTaken=0 → PCWrite=0. Both cases: ImGenControl=010, 3 cycles, count increments.
- Store (0100011) then JAL (1101111) back-to-back → MemWrite=1 only in MEM_WR, ImGenControl 001 then 011, JAL RegWrite with ResultSrc=10, RetireCount +2.
- Opcode 1110011 → TRAP, Illegal=1, no further MemReq, RetireCount frozen. Reset low → Illegal=0, state RST.
- Preload RetireCount near wrap (force or run 2^RETIRE_W with RETIRE_W=4) → 15 to 0 wrap. Reset asserted during MEM_WR wait → MemReq drops the next cycle, no RegWrite or retire.
